irq_priority_ctrl: RTL and testbench

IRQ_PRIORITY_CTRL -- requirements
Module: irq_priority_ctrl

---
 rtl/irq_priority_ctrl.sv | 132 +++++++++++++
 tb/tb_irq_priority_ctrl.sv | 231 +++++++++++++++++++++++
 2 files changed

// File: rtl/irq_priority_ctrl.sv
// Three-source prioritised interrupt controller: edge-latched pending bits, a two-state
// request FSM, an in-service (IRW) mask and vector generation. Macro IRQ_NEST_EN enables nested preemption.
module irq_priority_ctrl #(
    parameter int unsigned      WIDTH      = 32,
    parameter logic [WIDTH-1:0] VEC_BASE   = 32'h0000_0100,
    parameter logic [WIDTH-1:0] VEC_STRIDE = 32'h0000_0010
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [2:0]       IRQ,
    input  logic             ie,
    input  logic             int_ack,
    input  logic             eret,
    output logic             int_req,
    output logic [1:0]       int_id,
    output logic [WIDTH-1:0] int_vec,
    output logic [2:0]       IRW,
    output logic [2:0]       pending
);

    typedef enum logic {
        IDLE = 1'b0,
        REQ  = 1'b1
    } state_t;

    state_t     state, state_nxt;
    logic [1:0] id_nxt;
    logic [2:0] irw_nxt;
    logic [2:0] pend_nxt;
    logic [2:0] irq_p0;
    logic       armed_p0;
    logic [2:0] rise;
    logic [2:0] elig;
    logic       has_elig;
    logic [1:0] elig_id;
    logic [2:0] ack_set;
    logic [2:0] eret_clr;

    function automatic logic [1:0] top_idx(input logic [2:0] v);
        if (v[2])      return 2'd2;
        else if (v[1]) return 2'd1;
        else           return 2'd0;
    endfunction

    function automatic logic [2:0] top_onehot(input logic [2:0] v);
        if (v[2])      return 3'b100;
        else if (v[1]) return 3'b010;
        else if (v[0]) return 3'b001;
        else           return 3'b000;
    endfunction

`ifdef IRQ_NEST_EN
    // Sources strictly above the highest in-service source may preempt it.
    function automatic logic [2:0] above_top(input logic [2:0] v);
        if (v[2])      return 3'b000;
        else if (v[1]) return 3'b100;
        else if (v[0]) return 3'b110;
        else           return 3'b111;
    endfunction
`endif

    // ---- stage p0: IRQ sampling and edge detection ----
    // The first edge after reset only captures the line levels, so a line held
    // high through reset release is not seen as a rising edge.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            irq_p0   <= 3'b000;
            armed_p0 <= 1'b0;
        end else begin
            irq_p0   <= IRQ;
            armed_p0 <= 1'b1;
        end
    end

    assign rise = IRQ & ~irq_p0 & {3{armed_p0}};

    // ---- eligibility from registered pending and in-service state ----
`ifdef IRQ_NEST_EN
    assign elig = pending & above_top(IRW);
`else
    assign elig = (IRW == 3'b000) ? pending : 3'b000;
`endif

    assign has_elig = |elig;
    assign elig_id  = top_idx(elig);

    always_comb begin
        state_nxt = state;
        id_nxt    = int_id;
        ack_set   = 3'b000;
        eret_clr  = eret ? top_onehot(IRW) : 3'b000;
        case (state)
            IDLE: begin
                if (ie && has_elig) begin
                    state_nxt = REQ;
                    id_nxt    = elig_id;
                end
            end
            REQ: begin
                // Acknowledge beats withdrawal when both happen in one cycle.
                if (int_ack) begin
                    state_nxt = IDLE;
                    ack_set   = 3'b001 << int_id;
                end else if (!ie) begin
                    state_nxt = IDLE;
                end
            end
            default: state_nxt = IDLE;
        endcase
        irw_nxt  = (IRW & ~eret_clr) | ack_set;
        pend_nxt = (pending & ~ack_set) | rise;
    end

    // ---- stage p1: FSM, request id, pending and in-service registers ----
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state   <= IDLE;
            int_id  <= 2'd0;
            IRW     <= 3'b000;
            pending <= 3'b000;
        end else begin
            state   <= state_nxt;
            int_id  <= id_nxt;
            IRW     <= irw_nxt;
            pending <= pend_nxt;
        end
    end

    assign int_req = (state == REQ);
    assign int_vec = VEC_BASE + VEC_STRIDE * WIDTH'(int_id);

endmodule

// File: tb/tb_irq_priority_ctrl.sv
// Directed self-checking bench for irq_priority_ctrl; expectations are hand-derived per scenario.
module tb_irq_priority_ctrl;

    logic        clk;
    logic        rst;
    logic [2:0]  IRQ;
    logic        ie;
    logic        int_ack;
    logic        eret;
    logic        int_req;
    logic [1:0]  int_id;
    logic [31:0] int_vec;
    logic [2:0]  IRW;
    logic [2:0]  pending;

    int total;
    int bad;

    irq_priority_ctrl dut (
        .clk     (clk),
        .rst     (rst),
        .IRQ     (IRQ),
        .ie      (ie),
        .int_ack (int_ack),
        .eret    (eret),
        .int_req (int_req),
        .int_id  (int_id),
        .int_vec (int_vec),
        .IRW     (IRW),
        .pending (pending)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    initial begin
        #200000;
        $display("FAIL watchdog timeout");
        $fatal(1, "watchdog");
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        rst = 1'b1; IRQ = 3'b000; ie = 1'b0; int_ack = 1'b0; eret = 1'b0;
        step(); step();
        total++; if (int_req !== 1'b0) begin bad++; $display("FAIL rst_req got=%b want=0", int_req); end
        total++; if (int_id !== 2'd0) begin bad++; $display("FAIL rst_id got=%0d want=0", int_id); end
        total++; if (IRW !== 3'b000) begin bad++; $display("FAIL rst_irw got=%b want=000", IRW); end
        total++; if (pending !== 3'b000) begin bad++; $display("FAIL rst_pend got=%b want=000", pending); end
        rst = 1'b0;
        step(); step();
    endtask

    task automatic test_single();
        ie = 1'b1;
        IRQ = 3'b001; step();
        total++; if (pending !== 3'b001) begin bad++; $display("FAIL single_pend got=%b want=001", pending); end
        total++; if (int_req !== 1'b0) begin bad++; $display("FAIL single_early got=%b want=0", int_req); end
        IRQ = 3'b000; step();
        total++; if (int_req !== 1'b1) begin bad++; $display("FAIL single_req got=%b want=1", int_req); end
        total++; if (int_id !== 2'd0) begin bad++; $display("FAIL single_id got=%0d want=0", int_id); end
        total++; if (int_vec !== 32'h100) begin bad++; $display("FAIL single_vec got=%h want=100", int_vec); end
        int_ack = 1'b1; step(); int_ack = 1'b0;
        total++; if (IRW !== 3'b001) begin bad++; $display("FAIL single_irw got=%b want=001", IRW); end
        total++; if (pending !== 3'b000) begin bad++; $display("FAIL single_pclr got=%b want=000", pending); end
        total++; if (int_req !== 1'b0) begin bad++; $display("FAIL single_drop got=%b want=0", int_req); end
        eret = 1'b1; step(); eret = 1'b0;
        total++; if (IRW !== 3'b000) begin bad++; $display("FAIL single_eret got=%b want=000", IRW); end
        int_ack = 1'b1; step(); int_ack = 1'b0;
        total++; if (IRW !== 3'b000 || int_req !== 1'b0) begin bad++; $display("FAIL ack_idle irw=%b req=%b want 000/0", IRW, int_req); end
        eret = 1'b1; step(); eret = 1'b0;
        total++; if (IRW !== 3'b000) begin bad++; $display("FAIL eret_empty got=%b want=000", IRW); end
    endtask

    task automatic test_level();
        IRQ = 3'b010; step(); step();
        total++; if (int_req !== 1'b1 || int_id !== 2'd1) begin bad++; $display("FAIL level_req req=%b id=%0d want 1/1", int_req, int_id); end
        total++; if (int_vec !== 32'h110) begin bad++; $display("FAIL level_vec got=%h want=110", int_vec); end
        int_ack = 1'b1; step(); int_ack = 1'b0;
        step(); step();
        total++; if (pending !== 3'b000) begin bad++; $display("FAIL level_hold got=%b want=000", pending); end
        IRQ = 3'b000; eret = 1'b1; step(); eret = 1'b0;
        total++; if (IRW !== 3'b000 || int_req !== 1'b0) begin bad++; $display("FAIL level_end irw=%b req=%b want 000/0", IRW, int_req); end
    endtask

    task automatic test_priority();
        IRQ = 3'b101; step(); IRQ = 3'b000;
        total++; if (pending !== 3'b101) begin bad++; $display("FAIL prio_pend got=%b want=101", pending); end
        step();
        total++; if (int_req !== 1'b1 || int_id !== 2'd2) begin bad++; $display("FAIL prio_req req=%b id=%0d want 1/2", int_req, int_id); end
        total++; if (int_vec !== 32'h120) begin bad++; $display("FAIL prio_vec got=%h want=120", int_vec); end
        int_ack = 1'b1; step(); int_ack = 1'b0;
        total++; if (IRW !== 3'b100 || pending !== 3'b001) begin bad++; $display("FAIL prio_ack irw=%b pend=%b want 100/001", IRW, pending); end
        step(); step();
        total++; if (int_req !== 1'b0) begin bad++; $display("FAIL prio_wait got=%b want=0", int_req); end
        eret = 1'b1; step(); eret = 1'b0;
        total++; if (IRW !== 3'b000 || int_req !== 1'b0) begin bad++; $display("FAIL prio_eret irw=%b req=%b want 000/0", IRW, int_req); end
        step();
        total++; if (int_req !== 1'b1 || int_id !== 2'd0) begin bad++; $display("FAIL prio_low req=%b id=%0d want 1/0", int_req, int_id); end
        int_ack = 1'b1; step(); int_ack = 1'b0;
        total++; if (IRW !== 3'b001 || pending !== 3'b000) begin bad++; $display("FAIL prio_low_ack irw=%b pend=%b want 001/000", IRW, pending); end
    endtask

    task automatic test_nest();
        IRQ = 3'b010; step(); IRQ = 3'b000;
        step();
`ifdef IRQ_NEST_EN
        total++; if (int_req !== 1'b1 || int_id !== 2'd1) begin bad++; $display("FAIL nest_req req=%b id=%0d want 1/1", int_req, int_id); end
        int_ack = 1'b1; step(); int_ack = 1'b0;
        total++; if (IRW !== 3'b011) begin bad++; $display("FAIL nest_irw got=%b want=011", IRW); end
        eret = 1'b1; step(); eret = 1'b0;
        total++; if (IRW !== 3'b001) begin bad++; $display("FAIL nest_eret got=%b want=001", IRW); end
        eret = 1'b1; step(); eret = 1'b0;
        total++; if (IRW !== 3'b000) begin bad++; $display("FAIL nest_eret2 got=%b want=000", IRW); end
`else
        total++; if (int_req !== 1'b0) begin bad++; $display("FAIL flat_block got=%b want=0", int_req); end
        step();
        total++; if (int_req !== 1'b0 || pending !== 3'b010) begin bad++; $display("FAIL flat_block2 req=%b pend=%b want 0/010", int_req, pending); end
        eret = 1'b1; step(); eret = 1'b0;
        total++; if (IRW !== 3'b000) begin bad++; $display("FAIL flat_eret got=%b want=000", IRW); end
        step();
        total++; if (int_req !== 1'b1 || int_id !== 2'd1) begin bad++; $display("FAIL flat_req req=%b id=%0d want 1/1", int_req, int_id); end
        int_ack = 1'b1; step(); int_ack = 1'b0;
        total++; if (IRW !== 3'b010) begin bad++; $display("FAIL flat_irw got=%b want=010", IRW); end
        eret = 1'b1; step(); eret = 1'b0;
        total++; if (IRW !== 3'b000) begin bad++; $display("FAIL flat_eret2 got=%b want=000", IRW); end
`endif
    endtask

    task automatic test_withdraw();
        IRQ = 3'b001; step(); IRQ = 3'b000; step();
        total++; if (int_req !== 1'b1 || int_id !== 2'd0) begin bad++; $display("FAIL wd_req req=%b id=%0d want 1/0", int_req, int_id); end
        IRQ = 3'b100; step(); IRQ = 3'b000;
        total++; if (int_id !== 2'd0 || pending !== 3'b101) begin bad++; $display("FAIL wd_stable id=%0d pend=%b want 0/101", int_id, pending); end
        step();
        total++; if (int_req !== 1'b1 || int_id !== 2'd0) begin bad++; $display("FAIL wd_stable2 req=%b id=%0d want 1/0", int_req, int_id); end
        ie = 1'b0; step();
        total++; if (int_req !== 1'b0 || pending !== 3'b101) begin bad++; $display("FAIL wd_drop req=%b pend=%b want 0/101", int_req, pending); end
        step();
        total++; if (int_req !== 1'b0) begin bad++; $display("FAIL wd_idle got=%b want=0", int_req); end
        ie = 1'b1; step();
        total++; if (int_req !== 1'b1 || int_id !== 2'd2) begin bad++; $display("FAIL wd_resume req=%b id=%0d want 1/2", int_req, int_id); end
        int_ack = 1'b1; step(); int_ack = 1'b0;
        total++; if (IRW !== 3'b100 || pending !== 3'b001) begin bad++; $display("FAIL wd_ack irw=%b pend=%b want 100/001", IRW, pending); end
        eret = 1'b1; step(); eret = 1'b0;
        step();
        total++; if (int_req !== 1'b1 || int_id !== 2'd0) begin bad++; $display("FAIL wd_low req=%b id=%0d want 1/0", int_req, int_id); end
        ie = 1'b0; int_ack = 1'b1; step(); int_ack = 1'b0; ie = 1'b1;
        total++; if (IRW !== 3'b001 || pending !== 3'b000 || int_req !== 1'b0) begin bad++; $display("FAIL ack_wins irw=%b pend=%b req=%b want 001/000/0", IRW, pending, int_req); end
        eret = 1'b1; step(); eret = 1'b0;
    endtask

    task automatic test_eret_ack();
`ifdef IRQ_NEST_EN
        IRQ = 3'b001; step(); IRQ = 3'b000; step();
        int_ack = 1'b1; step(); int_ack = 1'b0;
        total++; if (IRW !== 3'b001) begin bad++; $display("FAIL ea_setup got=%b want=001", IRW); end
`endif
        IRQ = 3'b100; step(); IRQ = 3'b000; step();
        total++; if (int_req !== 1'b1 || int_id !== 2'd2) begin bad++; $display("FAIL ea_req req=%b id=%0d want 1/2", int_req, int_id); end
        eret = 1'b1; int_ack = 1'b1; step(); eret = 1'b0; int_ack = 1'b0;
        total++; if (IRW !== 3'b100 || pending !== 3'b000) begin bad++; $display("FAIL ea_irw irw=%b pend=%b want 100/000", IRW, pending); end
        eret = 1'b1; step(); eret = 1'b0;
        total++; if (IRW !== 3'b000) begin bad++; $display("FAIL ea_clear got=%b want=000", IRW); end
    endtask

    task automatic test_set_wins();
        IRQ = 3'b010; step(); IRQ = 3'b000; step();
        total++; if (int_req !== 1'b1 || int_id !== 2'd1) begin bad++; $display("FAIL sw_req req=%b id=%0d want 1/1", int_req, int_id); end
        IRQ = 3'b010; int_ack = 1'b1; step(); int_ack = 1'b0; IRQ = 3'b000;
        total++; if (pending !== 3'b010 || IRW !== 3'b010 || int_req !== 1'b0) begin bad++; $display("FAIL sw_pend pend=%b irw=%b req=%b want 010/010/0", pending, IRW, int_req); end
        step();
        total++; if (int_req !== 1'b0) begin bad++; $display("FAIL sw_block got=%b want=0", int_req); end
        eret = 1'b1; step(); eret = 1'b0;
        step();
        total++; if (int_req !== 1'b1 || int_id !== 2'd1) begin bad++; $display("FAIL sw_again req=%b id=%0d want 1/1", int_req, int_id); end
        int_ack = 1'b1; step(); int_ack = 1'b0;
        eret = 1'b1; step(); eret = 1'b0;
        total++; if (IRW !== 3'b000 || pending !== 3'b000) begin bad++; $display("FAIL sw_end irw=%b pend=%b want 000/000", IRW, pending); end
    endtask

    task automatic test_reset_mid();
        IRQ = 3'b010; step(); IRQ = 3'b000; step();
`ifdef IRQ_NEST_EN
        int_ack = 1'b1; step(); int_ack = 1'b0;
        IRQ = 3'b100; step(); IRQ = 3'b000; step();
        total++; if (int_req !== 1'b1 || IRW !== 3'b010) begin bad++; $display("FAIL rm_setup req=%b irw=%b want 1/010", int_req, IRW); end
`else
        total++; if (int_req !== 1'b1) begin bad++; $display("FAIL rm_setup req=%b want 1", int_req); end
        IRQ = 3'b001; step(); IRQ = 3'b000;
`endif
        IRQ = 3'b010; step();
        total++; if (pending === 3'b000) begin bad++; $display("FAIL rm_prepend got=%b want nonzero", pending); end
        rst = 1'b1; #1;
        total++; if (int_req !== 1'b0 || IRW !== 3'b000 || pending !== 3'b000) begin bad++; $display("FAIL rm_async req=%b irw=%b pend=%b want 0/000/000", int_req, IRW, pending); end
        step(); rst = 1'b0;
        step(); step(); step();
        total++; if (int_req !== 1'b0 || pending !== 3'b000) begin bad++; $display("FAIL rm_held req=%b pend=%b want 0/000", int_req, pending); end
        IRQ = 3'b000; step();
        IRQ = 3'b010; step();
        total++; if (pending !== 3'b010) begin bad++; $display("FAIL rm_rerise got=%b want=010", pending); end
        step();
        total++; if (int_req !== 1'b1 || int_id !== 2'd1) begin bad++; $display("FAIL rm_req req=%b id=%0d want 1/1", int_req, int_id); end
        IRQ = 3'b000;
        int_ack = 1'b1; step(); int_ack = 1'b0;
        eret = 1'b1; step(); eret = 1'b0;
    endtask

    initial begin
        total = 0;
        bad   = 0;
        test_reset();
        test_single();
        test_level();
        test_priority();
        test_nest();
        test_withdraw();
        test_eret_ack();
        test_set_wins();
        test_reset_mid();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
